// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite codes, initiator state encoding and alignment helper.
// Alignment checking is compiled in with AHB_INIT_ALIGN_CHECK_EN.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } init_state_e;

  function automatic logic misaligned(
    input logic [1:0] a,
    input logic [2:0] sz
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      (sz == HSIZE_BYTE): bad = 1'b0;
      (sz == HSIZE_HALF): bad = a[0];
      (sz == HSIZE_WORD): bad = |a;
      default:            bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahb_lite_initiator_if.sv
// AHB-Lite bus between one initiator and its slave/interconnect.
// Alignment checking is compiled in with AHB_INIT_ALIGN_CHECK_EN.
interface ahb_lite_initiator_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic              HMASTLOCK;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic              HRESP;
  logic [DATA_W-1:0] HRDATA;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE,
    output HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE,
    input  HBURST, HPROT, HMASTLOCK, HWDATA,
    output HREADY, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb_lite_initiator.sv
// Single-outstanding AHB-Lite initiator: command in, one SINGLE transfer, response out.
// Define AHB_INIT_ALIGN_CHECK_EN to reject misaligned or oversized commands locally.
module ahb_lite_initiator
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  ahb_lite_initiator_if.master bus
);

  init_state_e       state;
  logic [1:0]        htrans_q;
  logic [ADDR_W-1:0] haddr_q;
  logic              hwrite_q;
  logic [2:0]        hsize_q;
  logic [2:0]        hburst_q;
  logic [3:0]        hprot_q;
  logic [DATA_W-1:0] hwdata_q;
  logic [DATA_W-1:0] wdata_q;
  logic              reject;

`ifdef AHB_INIT_ALIGN_CHECK_EN
  assign reject = misaligned(cmd_addr[1:0], cmd_size);
`else
  assign reject = 1'b0;
`endif

  assign bus.HTRANS    = htrans_q;
  assign bus.HADDR     = haddr_q;
  assign bus.HWRITE    = hwrite_q;
  assign bus.HSIZE     = hsize_q;
  assign bus.HBURST    = hburst_q;
  assign bus.HPROT     = hprot_q;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HWDATA    = hwdata_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      htrans_q  <= HTRANS_IDLE;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      hsize_q   <= '0;
      hburst_q  <= '0;
      hprot_q   <= '0;
      hwdata_q  <= '0;
      wdata_q   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (reject) begin
              // Rejected locally: straight to response, bus untouched
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state    <= ST_ADDR;
              htrans_q <= HTRANS_NONSEQ;
              haddr_q  <= cmd_addr;
              hwrite_q <= cmd_write;
              hsize_q  <= cmd_size;
              hburst_q <= HBURST_SINGLE;
              hprot_q  <= HPROT_DEFAULT;
              wdata_q  <= cmd_wdata;
            end
          end
        end
        ST_ADDR: begin
          if (bus.HREADY) begin
            state    <= ST_DATA;
            htrans_q <= HTRANS_IDLE;
            if (hwrite_q) hwdata_q <= wdata_q;
          end
        end
        ST_DATA: begin
          // First ERROR cycle has HREADY=0 and simply waits here
          if (bus.HREADY) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= bus.HRESP;
            rsp_rdata <= hwrite_q ? '0 : bus.HRDATA;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
